i2c_master_burst_write: RTL and testbench

I2C_MASTER_BURST_WRITE -- requirements
Module: i2c_master_burst_write

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_quarter_tick.sv | 49 ++++
 rtl/i2c_master_burst_write.sv | 176 +++++++++++++++++
 tb/tb_i2c_master_burst_write.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the burst-write I2C master.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StStop
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timer: ticks every CLK_DIV cycles, advancing a 2-bit phase.
// While frozen (slave stretching SCL) the quarter restarts from zero.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       freeze_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick_o  = en_i && !freeze_i && (cnt_q == CW'(CLK_DIV - 1));
        if (!en_i || clr_i) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (freeze_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/i2c_master_burst_write.sv
// Open-drain I2C master that writes an address byte followed by up to MAX_BYTES data bytes,
// fetching each data byte on demand via data_req.
module i2c_master_burst_write
    import i2c_pkg::*;
#(
    parameter int unsigned  CLK_DIV   = 4,
    parameter int unsigned  MAX_BYTES = 16,
    localparam int unsigned NW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [6:0]    slave_addr,
    input  logic [NW-1:0] num_bytes,
    input  logic [7:0]    data_in,
    output logic          data_req,
    output logic          busy,
    output logic          done,
    output logic          ack_error,
    output logic          scl_oe,
    input  logic          scl_in,
    output logic          sda_oe,
    input  logic          sda_in
);

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          nack_q, nack_d;
    logic          smp_q, smp_d;
    logic          ack_err_q, ack_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic       tick, clr, freeze, scl_low;
    logic [1:0] phase;

    assign freeze = (state_q != StIdle) && !scl_oe && !scl_in;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (state_q != StIdle),
        .clr_i    (clr),
        .freeze_i (freeze),
        .tick_o   (tick),
        .phase_o  (phase)
    );

    // Line drivers depend only on registered state so the stretch path has no loop.
    assign scl_low = (phase == Q0) || (phase == Q1);

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            StStart: sda_oe = 1'b1;
            StAddr, StData: begin
                scl_oe = scl_low;
                sda_oe = ~shift_q[7];
            end
            StAddrAck, StDataAck: scl_oe = scl_low;
            StStop: begin
                scl_oe = scl_low;
                sda_oe = (phase != Q3);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        rem_d     = rem_q;
        nack_d    = nack_q;
        smp_d     = 1'b0;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        data_req  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = {slave_addr, RW_WRITE};
                    rem_d     = (num_bytes > NW'(MAX_BYTES)) ? NW'(MAX_BYTES) : num_bytes;
                    bit_d     = '0;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick && phase == Q1) begin
                    clr     = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr, StData: begin
                if (tick && phase == Q3) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (state_q == StAddr) ? StAddrAck : StDataAck;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            StAddrAck, StDataAck: begin
                smp_d = tick && (phase == Q2);
                // First cycle of q3: ACK decides both the count and whether to fetch a byte.
                if (smp_q) begin
                    nack_d = sda_in;
                    if (sda_in) begin
                        ack_err_d = 1'b1;
                    end else if (state_q == StAddrAck) begin
                        if (rem_q != '0) begin
                            data_req = 1'b1;
                            shift_d  = data_in;
                        end
                    end else begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q > NW'(1)) begin
                            data_req = 1'b1;
                            shift_d  = data_in;
                        end
                    end
                end
                if (tick && phase == Q3) begin
                    state_d = (nack_q || rem_q == '0) ? StStop : StData;
                end
            end
            StStop: begin
                if (tick && phase == Q3) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_q     <= '0;
            rem_q     <= '0;
            nack_q    <= 1'b0;
            smp_q     <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            rem_q     <= rem_d;
            nack_q    <= nack_d;
            smp_q     <= smp_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_err_q;

endmodule

// File: tb/tb_i2c_master_burst_write.sv
// Scoreboard bench: a bus monitor acts as the slave, decodes bytes off SCL/SDA and checks
// them and per-transaction results against queues filled when each transaction is issued.
module tb_i2c_master_burst_write;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned MAX_BYTES = 16;
    localparam int unsigned NW        = 5;

    typedef struct {
        logic err;
        int   reqs;
        int   cyc;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6:0]    slave_addr;
    logic [NW-1:0] num_bytes;
    logic [7:0]    data_in;
    logic          data_req, busy, done, ack_error;
    logic          scl_oe, scl_in, sda_oe, sda_in;

    logic       stretch   = 1'b0;
    logic       slave_drv = 1'b0;
    logic [7:0] tx_data [16];
    int         req_idx    = 0;
    int         nack_at    = 99;
    bit         stretch_en = 1'b0;
    bit         done_flag  = 1'b0;
    int         n_cmp      = 0;
    int         n_err      = 0;

    logic [7:0] exp_bytes [$];
    res_t       exp_res [$];

    // Monitor state
    logic       scl_now, sda_now;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0;
    bit         stop_seen = 1'b0;
    int         bitcnt = 0, byte_idx = 0, rel_cnt = 0, str_left = 0, cyc = 0, t0 = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] e_byte;
    res_t       r_mon;

    always #5 clk = ~clk;

    assign scl_in  = ~scl_oe & ~stretch;
    assign sda_in  = ~sda_oe & ~slave_drv;
    assign data_in = tx_data[req_idx[3:0]];

    i2c_master_burst_write #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .slave_addr (slave_addr),
        .num_bytes  (num_bytes),
        .data_in    (data_in),
        .data_req   (data_req),
        .busy       (busy),
        .done       (done),
        .ack_error  (ack_error),
        .scl_oe     (scl_oe),
        .scl_in     (scl_in),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the data source after each data_req cycle has been latched by the DUT.
    initial begin : req_counter
        bit p;
        forever begin
            @(negedge clk);
            p = (data_req === 1'b1);
            @(posedge clk);
            #1;
            if (p) req_idx++;
        end
    end

    initial begin : bus_monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stretch   = 1'b0;
                slave_drv = 1'b0;
                str_left  = 0;
                bitcnt    = 0;
                stop_seen = 1'b0;
                prev_busy = 1'b0;
                prev_scl  = ~scl_oe;
                prev_sda  = ~sda_oe;
                prev_oe   = scl_oe;
                continue;
            end
            // Slave-side stretch: hold SCL low for 20 cycles from the release of bit 3.
            if (stretch_en && prev_oe && !scl_oe) begin
                rel_cnt++;
                if (rel_cnt == 4) str_left = 20;
            end
            prev_oe = scl_oe;
            stretch = (str_left > 0);
            if (str_left > 0) str_left--;
            scl_now = ~scl_oe & ~stretch;
            sda_now = ~sda_oe & ~slave_drv;

            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                bitcnt    = 0;
                byte_idx  = 0;
                rel_cnt   = 0;
                stop_seen = 1'b0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                stop_seen = 1'b1;
            end
            if (!prev_scl && scl_now) begin
                if (bitcnt < 8) begin
                    sh = {sh[6:0], sda_now};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (exp_bytes.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_byte: got 0x%0h, expected none", sh);
                        end else begin
                            e_byte = exp_bytes.pop_front();
                            check("sda_byte", {24'd0, sh}, {24'd0, e_byte});
                        end
                    end
                end else begin
                    bitcnt = 0;
                    byte_idx++;
                end
            end
            if (prev_scl && !scl_now) slave_drv = (bitcnt == 8) && (byte_idx != nack_at);
            prev_scl = scl_now;
            prev_sda = sda_now;

            if (busy && !prev_busy) t0 = cyc;
            prev_busy = busy;
            if (done) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected none");
                end else begin
                    r_mon = exp_res.pop_front();
                    check("ack_error", {31'd0, ack_error}, {31'd0, r_mon.err});
                    check("data_req_count", req_idx, r_mon.reqs);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    check("stop_seen", {31'd0, stop_seen}, 32'd1);
                    n_cmp++;
                    if ((cyc - t0) < r_mon.cyc - 1 || (cyc - t0) > r_mon.cyc + 1) begin
                        n_err++;
                        $display("FAIL cycles: got %0d, expected %0d +-1", cyc - t0, r_mon.cyc);
                    end
                end
                done_flag = 1'b1;
            end
        end
    end

    task automatic run_tx(input logic [6:0] a, input int n, input int nack, input bit str,
                          input bit poke, input bit do_rst, input logic [7:0] e_ab,
                          input int e_req, input logic e_err, input int e_cyc);
        res_t r;
        nack_at    = nack;
        stretch_en = str;
        req_idx    = 0;
        done_flag  = 1'b0;
        rel_cnt    = 0;
        exp_bytes.push_back(e_ab);
        for (int i = 0; i < e_req; i++) exp_bytes.push_back(tx_data[i]);
        if (!do_rst) begin
            r.err  = e_err;
            r.reqs = e_req;
            r.cyc  = e_cyc;
            exp_res.push_back(r);
        end
        @(negedge clk);
        slave_addr = a;
        num_bytes  = NW'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (do_rst) begin
            for (int k = 0; k < 2000 && req_idx == 0; k++) @(negedge clk);
            if (req_idx == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_timeout: got no data_req, expected one");
            end
            repeat (40) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
            check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_ack_error", {31'd0, ack_error}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int k = 0; k < 5000 && !done_flag; k++) @(negedge clk);
            if (!done_flag) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout: got no done, expected done");
            end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        slave_addr = '0;
        num_bytes  = '0;
        for (int i = 0; i < 16; i++) tx_data[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_data_req", {31'd0, data_req}, 32'd0);
        check("reset_ack_error", {31'd0, ack_error}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-byte burst, all ACK, with an ignored start pulse while busy
        tx_data[0] = 8'hA5;
        tx_data[1] = 8'h3C;
        run_tx(7'h50, 2, 99, 1'b0, 1'b1, 1'b0, 8'hA0, 2, 1'b0, 456);
        // Address NACK
        run_tx(7'h2A, 2, 0, 1'b0, 1'b0, 1'b0, 8'h54, 0, 1'b1, 168);
        // NACK on second data byte of three
        tx_data[0] = 8'h01;
        tx_data[1] = 8'h02;
        tx_data[2] = 8'h03;
        run_tx(7'h11, 3, 2, 1'b0, 1'b0, 1'b0, 8'h22, 2, 1'b1, 456);
        // Address-only transaction
        run_tx(7'h7F, 0, 99, 1'b0, 1'b0, 1'b0, 8'hFE, 0, 1'b0, 168);
        // Clock stretch of 20 cycles on address bit 3
        tx_data[0] = 8'hC3;
        run_tx(7'h33, 1, 99, 1'b1, 1'b0, 1'b0, 8'h66, 1, 1'b0, 332);
        // Count above MAX_BYTES clamps to 16
        for (int i = 0; i < 16; i++) tx_data[i] = 8'(8'h10 * i + 3);
        run_tx(7'h01, 31, 99, 1'b0, 1'b0, 1'b0, 8'h02, 16, 1'b0, 2472);
        // Reset during the first data byte
        tx_data[0] = 8'h96;
        tx_data[1] = 8'h69;
        run_tx(7'h45, 2, 99, 1'b0, 1'b0, 1'b1, 8'h8A, 0, 1'b0, 0);
        // Normal transaction after reset
        tx_data[0] = 8'h5A;
        run_tx(7'h12, 1, 99, 1'b0, 1'b0, 1'b0, 8'h24, 1, 1'b0, 312);

        check("bytes_outstanding", exp_bytes.size(), 32'd0);
        check("results_outstanding", exp_res.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
